// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, sizes and helpers for the associative write-back cache
package cache_pkg;

  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_DATA_W = 8;
  localparam int CACHE_LINES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [CACHE_ADDR_W-1:0] tag;
    logic [CACHE_DATA_W-1:0] data;
  } line_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cache_assoc_wb_if.sv
// rtl/cache_assoc_wb_if.sv - CPU request/response and backing-RAM handshake bundle
interface cache_assoc_wb_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // slave = the cache controller, master = CPU front end plus RAM
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_lru_ages.sv
// rtl/cache_lru_ages.sv - true-LRU age array with victim selection and touch update
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int LINES = CACHE_LINES,
  parameter int AGE_W = clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [LINES-1:0] valid,
  input  logic             touch,
  input  logic [AGE_W-1:0] touch_idx,
  output logic [AGE_W-1:0] victim
);

  logic [AGE_W-1:0] age [LINES];

  // Touching line k ages every younger line by one, so ages stay a permutation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) age[i] <= AGE_W'(i);
    end else if (touch) begin
      for (int i = 0; i < LINES; i++) begin
        if (AGE_W'(i) == touch_idx)
          age[i] <= '0;
        else if (age[i] < age[touch_idx])
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Lowest-index invalid line wins; otherwise the oldest line.
  always_comb begin
    victim = '0;
    for (int i = 0; i < LINES; i++)
      if (age[i] == AGE_W'(LINES - 1)) victim = AGE_W'(i);
    for (int i = LINES - 1; i >= 0; i--)
      if (!valid[i]) victim = AGE_W'(i);
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// rtl/cache_assoc_wb.sv - fully associative write-back write-allocate cache controller
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int LINES  = CACHE_LINES
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef CACHE_STATS_EN
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count,
`endif
  cache_assoc_wb_if.slave    bus
);

  localparam int IDX_W = clog2(LINES);

  state_t            state, state_nxt;
  line_t             lines [LINES];
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IDX_W-1:0]  victim_q;
  logic [IDX_W-1:0]  victim;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [LINES-1:0]  valid_vec;
  logic              touch;
  logic [IDX_W-1:0]  touch_idx;

  cache_lru_ages #(
    .LINES (LINES),
    .AGE_W (IDX_W)
  ) u_lru (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid     (valid_vec),
    .touch     (touch),
    .touch_idx (touch_idx),
    .victim    (victim)
  );

  // No duplicate tag is ever installed, so at most one line matches.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    valid_vec = '0;
    for (int i = 0; i < LINES; i++) begin
      valid_vec[i] = lines[i].valid;
      if (lines[i].valid && lines[i].tag == addr_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    touch          = 1'b0;
    touch_idx      = victim_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          touch     = 1'b1;
          touch_idx = hit_idx;
          state_nxt = RESP;
        end else if (lines[victim].dirty) begin
          state_nxt = WB;
        end else if (wr_q) begin
          touch     = 1'b1;
          touch_idx = victim;
          state_nxt = RESP;
        end else begin
          state_nxt = FILL;
        end
      end
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = lines[victim_q].tag;
        bus.mem_wdata = lines[victim_q].data;
        if (bus.mem_ack) begin
          touch     = wr_q;
          state_nxt = wr_q ? RESP : FILL;
        end
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ack) begin
          touch     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) lines[i] <= '0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      victim_q       <= '0;
      bus.resp_rdata <= '0;
      bus.resp_hit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        LOOKUP: begin
          if (hit) begin
            bus.resp_hit <= 1'b1;
            if (wr_q) begin
              lines[hit_idx].data  <= wdata_q;
              lines[hit_idx].dirty <= 1'b1;
              bus.resp_rdata       <= wdata_q;
            end else begin
              bus.resp_rdata <= lines[hit_idx].data;
            end
          end else begin
            bus.resp_hit <= 1'b0;
            victim_q     <= victim;
            if (!lines[victim].dirty && wr_q) begin
              lines[victim]  <= '{valid: 1'b1, dirty: 1'b1, tag: addr_q, data: wdata_q};
              bus.resp_rdata <= wdata_q;
            end
          end
        end
        WB: begin
          if (bus.mem_ack) begin
            if (wr_q) begin
              lines[victim_q] <= '{valid: 1'b1, dirty: 1'b1, tag: addr_q, data: wdata_q};
              bus.resp_rdata  <= wdata_q;
            end else begin
              lines[victim_q].dirty <= 1'b0;
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            lines[victim_q] <= '{valid: 1'b1, dirty: 1'b0, tag: addr_q, data: bus.mem_rdata};
            bus.resp_rdata  <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (bus.resp_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_assoc_wb.sv
// tb/tb_cache_assoc_wb.sv - directed self-checking bench for cache_assoc_wb
module tb_cache_assoc_wb;

  logic clock;
  logic reset_n;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_assoc_wb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  cache_assoc_wb #(.ADDR_W(8), .DATA_W(8), .LINES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert;
  int n_fail;
  int ack_delay;
  int wb_count, fill_count, req_cycles, txn_no;
  int last_wb_seq, last_fill_seq;
  logic [7:0] last_wb_addr, last_wb_data, last_fill_addr;
  logic [7:0] rd;
  logic       hit;
  int         edges;
  int         w0, f0, c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: acks ack_delay cycles after mem_req is first seen, checks field stability.
  initial begin : ram_model
    logic [7:0]  ram [256];
    logic [16:0] cap;
    int          cnt;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 8'h80);
    ram[8'h64] = 8'h05;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    cnt = 0;
    cap = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_ack || !bus.mem_req) cnt = 0;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        req_cycles++;
        if (cnt == 0) cap = {bus.mem_write, bus.mem_addr, bus.mem_wdata};
        else check("mem_stable", 32'({bus.mem_write, bus.mem_addr, bus.mem_wdata}), 32'(cap));
        if (cnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          txn_no++;
          if (bus.mem_write) begin
            ram[bus.mem_addr] = bus.mem_wdata;
            wb_count++;
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_wdata;
            last_wb_seq  = txn_no;
          end else begin
            bus.mem_rdata  = ram[bus.mem_addr];
            fill_count++;
            last_fill_addr = bus.mem_addr;
            last_fill_seq  = txn_no;
          end
        end
        cnt++;
      end
    end
  end

  // Issue one request from IDLE; returns at the negedge after the response cycle.
  task automatic cpu(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("req_ready_busy", bus.req_ready, 0);
    edges = 1;
    while (!bus.resp_valid && edges < 200) begin
      @(negedge clock);
      edges++;
    end
    check("resp_valid", bus.resp_valid, 1);
    rd  = bus.resp_rdata;
    hit = bus.resp_hit;
    @(negedge clock);
    check("resp_pulse", bus.resp_valid, 0);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] addr,
                           input logic [7:0] exp_d, input logic exp_h);
    cpu(1'b0, addr, 8'h00);
    check({tag, "_rdata"}, rd, exp_d);
    check({tag, "_hit"}, hit, exp_h);
  endtask

  initial begin : stimulus
    n_assert = 0; n_fail = 0; ack_delay = 3;
    wb_count = 0; fill_count = 0; req_cycles = 0; txn_no = 0;
    last_wb_seq = 0; last_fill_seq = 0;
    last_wb_addr = '0; last_wb_data = '0; last_fill_addr = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // cold read miss, RAM acks 3 cycles late
    w0 = wb_count; f0 = fill_count;
    rd_expect("t1", 8'h64, 8'h05, 1'b0);
    check("t1_fills", fill_count - f0, 1);
    check("t1_fill_addr", last_fill_addr, 8'h64);
    check("t1_no_wb", wb_count - w0, 0);
    check("t1_latency", edges, 6);
    c0 = req_cycles;
    rd_expect("t1_rep", 8'h64, 8'h05, 1'b1);
    check("t1_rep_latency", edges, 2);
    check("t1_rep_no_mem", req_cycles - c0, 0);

    // same-cycle ack; LRU victim choice
    ack_delay = 0;
    rd_expect("t2_10", 8'h10, 8'h90, 1'b0);
    check("t2_latency_ack0", edges, 3);
    rd_expect("t2_11", 8'h11, 8'h91, 1'b0);
    rd_expect("t2_12", 8'h12, 8'h92, 1'b0);
    rd_expect("t2_13", 8'h13, 8'h93, 1'b0);
    rd_expect("t2_10_hit", 8'h10, 8'h90, 1'b1);
    w0 = wb_count;
    rd_expect("t2_14", 8'h14, 8'h94, 1'b0);
    check("t2_14_fill_addr", last_fill_addr, 8'h14);
    check("t2_14_no_wb", wb_count - w0, 0);
    rd_expect("t2_10_again", 8'h10, 8'h90, 1'b1);

    // write allocate, later dirty eviction precedes the fill
    ack_delay = 1;
    c0 = req_cycles;
    cpu(1'b1, 8'h20, 8'hAA);
    check("t3_wr_rdata", rd, 8'hAA);
    check("t3_wr_hit", hit, 0);
    check("t3_wr_latency", edges, 2);
    check("t3_wr_no_mem", req_cycles - c0, 0);
    w0 = wb_count;
    rd_expect("t3_21", 8'h21, 8'hA1, 1'b0);
    rd_expect("t3_22", 8'h22, 8'hA2, 1'b0);
    rd_expect("t3_23", 8'h23, 8'hA3, 1'b0);
    check("t3_clean_no_wb", wb_count - w0, 0);
    rd_expect("t3_24", 8'h24, 8'hA4, 1'b0);
    check("t3_wb_count", wb_count - w0, 1);
    check("t3_wb_addr", last_wb_addr, 8'h20);
    check("t3_wb_data", last_wb_data, 8'hAA);
    check("t3_wb_before_fill", last_wb_seq < last_fill_seq, 1);
    check("t3_fill_addr", last_fill_addr, 8'h24);
    check("t3_latency_wb", edges, 6);

    // write hit, then evict it; clean evictions write nothing
    c0 = req_cycles;
    cpu(1'b1, 8'h23, 8'h3C);
    check("t4_wr_hit", hit, 1);
    check("t4_wr_rdata", rd, 8'h3C);
    check("t4_wr_no_mem", req_cycles - c0, 0);
    w0 = wb_count;
    rd_expect("t4_30", 8'h30, 8'hB0, 1'b0);
    rd_expect("t4_31", 8'h31, 8'hB1, 1'b0);
    rd_expect("t4_32", 8'h32, 8'hB2, 1'b0);
    check("t4_clean_no_wb", wb_count - w0, 0);
    rd_expect("t4_33", 8'h33, 8'hB3, 1'b0);
    check("t4_wb_count", wb_count - w0, 1);
    check("t4_wb_addr", last_wb_addr, 8'h23);
    check("t4_wb_data", last_wb_data, 8'h3C);
    rd_expect("t4_23_back", 8'h23, 8'h3C, 1'b0);

    // asynchronous reset in the middle of a fill
    ack_delay = 20;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h50;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    check("t5_fill_req", bus.mem_req, 1);
    check("t5_fill_write", bus.mem_write, 0);
    check("t5_fill_addr", bus.mem_addr, 8'h50);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_mem_req", bus.mem_req, 0);
    check("t5_rst_resp_valid", bus.resp_valid, 0);
    check("t5_rst_req_ready", bus.req_ready, 1);
    check("t5_rst_mem_addr", bus.mem_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    ack_delay = 1;
    rd_expect("t5_50", 8'h50, 8'hD0, 1'b0);
    rd_expect("t5_50_hit", 8'h50, 8'hD0, 1'b1);
    rd_expect("t5_51", 8'h51, 8'hD1, 1'b0);
    rd_expect("t5_52", 8'h52, 8'hD2, 1'b0);
    rd_expect("t5_51_hit", 8'h51, 8'hD1, 1'b1);
`ifdef CACHE_STATS_EN
    check("stats_hits", hit_count, 2);
    check("stats_misses", miss_count, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
